// File: rtl/color_sensor_emu_pkg.sv
// Shared encodings, scale multipliers, FSM state enum and half-period helpers
// for the colour-sensor frequency emulator.
package color_sensor_emu_pkg;

    typedef enum logic [1:0] {
        RED   = 2'b00,
        BLUE  = 2'b01,
        CLEAR = 2'b10,
        GREEN = 2'b11
    } filter_e;

    typedef enum logic [1:0] {
        PD   = 2'b00,
        S2   = 2'b01,
        S20  = 2'b10,
        S100 = 2'b11
    } scale_e;

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_SETTLE = 2'b01,
        ST_RUN    = 2'b10
    } state_e;

    localparam logic [21:0] MULT_S100 = 22'd1;
    localparam logic [21:0] MULT_S20  = 22'd5;
    localparam logic [21:0] MULT_S2   = 22'd50;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // A zero base is promoted to 1 so the half-period can never be empty.
    function automatic logic [21:0] cse_eff_half(input logic [15:0] base, input logic [1:0] scl);
        logic [21:0] b;
        b = (base == 16'd0) ? 22'd1 : {6'd0, base};
        case (scl)
            S100:    cse_eff_half = b * MULT_S100;
            S20:     cse_eff_half = b * MULT_S20;
            S2:      cse_eff_half = b * MULT_S2;
            default: cse_eff_half = b;
        endcase
    endfunction

    function automatic logic [15:0] cse_lfsr_step(input logic [15:0] lfsr);
        cse_lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    endfunction

    function automatic logic [21:0] cse_jitter(input logic [21:0] half, input logic [15:0] lfsr);
        if (lfsr[0]) begin
            cse_jitter = half + 22'd1;
        end else if (lfsr[1]) begin
            cse_jitter = (half > 22'd1) ? (half - 22'd1) : 22'd1;
        end else begin
            cse_jitter = half;
        end
    endfunction

endpackage

// File: rtl/color_sensor_emu_if.sv
// Configuration bus for writing per-channel base half-periods.
interface color_sensor_emu_if;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [15:0] cfg_half;

    modport master (output cfg_we, output cfg_sel, output cfg_half);
    modport slave  (input  cfg_we, input  cfg_sel, input  cfg_half);
endinterface

// File: rtl/cse_half_timer.sv
// Half-period reload counter and wave toggle; with CSE_NOISE_EN defined an
// LFSR jitters every reloaded half-period.
module cse_half_timer
    import color_sensor_emu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        load,
    input  logic        run,
    input  logic [21:0] eff_half,
    output logic        wave_next
);

    logic [21:0] cnt_r;
    logic [21:0] cnt_nxt;
    logic [21:0] half_r;
    logic [21:0] half_nxt;
    logic [21:0] reload_s;
    logic        wave_r;
    logic        toggle_s;

`ifdef CSE_NOISE_EN
    logic [15:0] lfsr_r;

    assign reload_s = cse_jitter(eff_half, lfsr_r);

    // Noise source advances once per wave toggle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else if (toggle_s) begin
            lfsr_r <= cse_lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`else
    assign reload_s = eff_half;
`endif

    // Half-period is only re-sampled on reload, so config writes never cut a half short.
    always_comb begin
        cnt_nxt   = cnt_r;
        half_nxt  = half_r;
        wave_next = wave_r;
        toggle_s  = 1'b0;
        if (clr) begin
            cnt_nxt   = 22'd0;
            wave_next = 1'b0;
        end else if (load) begin
            cnt_nxt   = 22'd0;
            wave_next = 1'b0;
            half_nxt  = reload_s;
        end else if (run) begin
            if (cnt_r == half_r - 22'd1) begin
                toggle_s  = 1'b1;
                wave_next = ~wave_r;
                cnt_nxt   = 22'd0;
                half_nxt  = reload_s;
            end else begin
                cnt_nxt = cnt_r + 22'd1;
            end
        end else begin
            cnt_nxt = cnt_r;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r  <= 22'd0;
            half_r <= 22'd1;
            wave_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt;
            half_r <= half_nxt;
            wave_r <= wave_next;
        end
    end

endmodule

// File: rtl/color_sensor_emu.sv
// Colour-sensor frequency emulator top: OFF/SETTLE/RUN FSM, base half-period
// registers and output gating (optional jitter via CSE_NOISE_EN in the timer).
module color_sensor_emu
    import color_sensor_emu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int DEF_HALF      = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               scale,
    input  logic [1:0]               filter,
    input  logic                     oe_n,
    color_sensor_emu_if.slave        cfg,
    output logic                     sensor_freq,
    output logic                     settled
);

    localparam logic [1:0] OFF    = ST_OFF;
    localparam logic [1:0] SETTLE = ST_SETTLE;
    localparam logic [1:0] RUN    = ST_RUN;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt;
    logic [15:0] settle_r;
    logic [15:0] settle_nxt;
    logic [1:0]  scale_r;
    logic [1:0]  filter_r;
    logic [15:0] base_r [4];
    logic [21:0] eff_half_s;
    logic        changed_s;
    logic        wave_next_s;

    assign changed_s  = (scale != scale_r) || (filter != filter_r);
    assign eff_half_s = cse_eff_half(base_r[filter], scale);

    // Next-state logic; any filter/scale change restarts the settle window.
    always_comb begin
        state_nxt  = state_r;
        settle_nxt = settle_r;
        if (scale == PD) begin
            state_nxt  = OFF;
            settle_nxt = 16'd0;
        end else begin
            case (state_r)
                OFF: begin
                    state_nxt  = SETTLE;
                    settle_nxt = 16'd0;
                end
                SETTLE: begin
                    if (changed_s) begin
                        settle_nxt = 16'd0;
                    end else if (settle_r == 16'(SETTLE_CYCLES - 1)) begin
                        state_nxt  = RUN;
                        settle_nxt = 16'd0;
                    end else begin
                        settle_nxt = settle_r + 16'd1;
                    end
                end
                RUN: begin
                    if (changed_s) begin
                        state_nxt  = SETTLE;
                        settle_nxt = 16'd0;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                default: begin
                    state_nxt  = OFF;
                    settle_nxt = 16'd0;
                end
            endcase
        end
    end

    cse_half_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_nxt != RUN),
        .load      ((state_r == SETTLE) && (state_nxt == RUN)),
        .run       ((state_r == RUN) && (state_nxt == RUN)),
        .eff_half  (eff_half_s),
        .wave_next (wave_next_s)
    );

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= OFF;
            settle_r    <= 16'd0;
            scale_r     <= 2'b00;
            filter_r    <= 2'b00;
            sensor_freq <= 1'b0;
            settled     <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            settle_r    <= settle_nxt;
            scale_r     <= scale;
            filter_r    <= filter;
            sensor_freq <= wave_next_s & ~oe_n;
            settled     <= (state_nxt == RUN);
        end
    end

    // Per-channel base half-period registers; reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                base_r[i] <= 16'(DEF_HALF);
            end
        end else if (cfg.cfg_we) begin
            base_r[cfg.cfg_sel] <= cfg.cfg_half;
        end else begin
            base_r <= base_r;
        end
    end

endmodule

// File: tb/tb_color_sensor_emu.sv
// Directed table-driven bench for color_sensor_emu plus multi-cycle corner sequences.
module tb_color_sensor_emu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] scale;
    logic [1:0] filter;
    logic       oe_n;
    logic       sensor_freq;
    logic       settled;

    color_sensor_emu_if cfg_bus ();

    color_sensor_emu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scale       (scale),
        .filter      (filter),
        .oe_n        (oe_n),
        .cfg         (cfg_bus.slave),
        .sensor_freq (sensor_freq),
        .settled     (settled)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [15:0] half;
        logic [1:0]  scl;
        logic [1:0]  flt;
        int          zeros;
        int          hi;
        int          lo;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        scale = 2'b00;
        filter = 2'b00;
        oe_n = 1'b0;
        cfg_bus.cfg_we = 1'b0;
        cfg_bus.cfg_sel = 2'b00;
        cfg_bus.cfg_half = 16'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [15:0] half);
        cfg_bus.cfg_we = 1'b1;
        cfg_bus.cfg_sel = sel;
        cfg_bus.cfg_half = half;
        @(negedge clk);
        cfg_bus.cfg_we = 1'b0;
    endtask

    // Counts consecutive samples at lvl, starting from init; bounded.
    task automatic count_level(input logic lvl, input int init, output int n);
        n = init;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (sensor_freq !== lvl) return;
            n++;
        end
    endtask

    initial begin
        int z, h, l, errs;
        logic exp_b;

        vecs[0] = '{1'b0, 16'd0,  2'b11, 2'b00, 116,  100,  100};
        vecs[1] = '{1'b0, 16'd0,  2'b10, 2'b01, 516,  500,  500};
        vecs[2] = '{1'b0, 16'd0,  2'b01, 2'b10, 5016, 5000, 5000};
        vecs[3] = '{1'b1, 16'd40, 2'b11, 2'b11, 56,   40,   40};
        vecs[4] = '{1'b1, 16'd0,  2'b11, 2'b00, 17,   1,    1};
        vecs[5] = '{1'b1, 16'd0,  2'b10, 2'b11, 21,   5,    5};
        vecs[6] = '{1'b1, 16'd7,  2'b01, 2'b01, 366,  350,  350};

        // reset state
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_freq", {31'd0, sensor_freq}, 32'd0);
        check("rst_settled", {31'd0, settled}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            if (vecs[i].wr) cfg_write(vecs[i].flt, vecs[i].half);
            scale = vecs[i].scl;
            filter = vecs[i].flt;
            count_level(1'b0, 0, z);
            count_level(1'b1, 1, h);
            count_level(1'b0, 1, l);
            check($sformatf("vec%0d_first_low", i), z, vecs[i].zeros);
            check($sformatf("vec%0d_high", i), h, vecs[i].hi);
            check($sformatf("vec%0d_low", i), l, vecs[i].lo);
        end

        // settled during SETTLE/RUN, power-down within one cycle
        do_reset();
        scale = 2'b11;
        repeat (5) @(negedge clk);
        check("settling_flag", {31'd0, settled}, 32'd0);
        count_level(1'b0, 5, z);
        check("pd_first_low", z, 116);
        check("run_settled", {31'd0, settled}, 32'd1);
        scale = 2'b00;
        @(negedge clk);
        check("pd_freq", {31'd0, sensor_freq}, 32'd0);
        check("pd_settled", {31'd0, settled}, 32'd0);

        // write green and switch to green in the same cycle while running
        do_reset();
        scale = 2'b11;
        count_level(1'b0, 0, z);
        repeat (10) @(negedge clk);
        cfg_bus.cfg_we = 1'b1;
        cfg_bus.cfg_sel = 2'b11;
        cfg_bus.cfg_half = 16'd40;
        filter = 2'b11;
        @(negedge clk);
        cfg_bus.cfg_we = 1'b0;
        check("flt_chg_low_now", {31'd0, sensor_freq}, 32'd0);
        count_level(1'b0, 1, z);
        count_level(1'b1, 1, h);
        count_level(1'b0, 1, l);
        check("flt_chg_first_low", z, 56);
        check("flt_chg_high", h, 40);
        check("flt_chg_low", l, 40);

        // mid-half write to the active channel applies only from the next toggle
        do_reset();
        scale = 2'b11;
        count_level(1'b0, 0, z);
        repeat (49) @(negedge clk);
        cfg_write(2'b00, 16'd30);
        count_level(1'b1, 51, h);
        count_level(1'b0, 1, l);
        check("mid_write_cur_half", h, 100);
        check("mid_write_next_low", l, 30);
        count_level(1'b1, 1, h);
        check("mid_write_next_high", h, 30);

        // oe_n gating for 150 cycles against an ungated phase model
        do_reset();
        scale = 2'b11;
        count_level(1'b0, 0, z);
        check("oe_first_low", z, 116);
        errs = 0;
        for (int j = 1; j <= 450; j++) begin
            @(negedge clk);
            exp_b = ((j % 200) < 100) && !(j >= 31 && j <= 180);
            if (sensor_freq !== exp_b) errs++;
            if (j == 30) oe_n = 1'b1;
            if (j == 180) oe_n = 1'b0;
        end
        check("oe_phase_errs", errs, 0);

        // reset mid-RUN while high, with a write in the same cycle
        do_reset();
        cfg_write(2'b00, 16'd30);
        scale = 2'b11;
        count_level(1'b0, 0, z);
        check("rst_run_first_low", z, 46);
        repeat (5) @(negedge clk);
        check("rst_run_high", {31'd0, sensor_freq}, 32'd1);
        rst_n = 1'b0;
        cfg_bus.cfg_we = 1'b1;
        cfg_bus.cfg_sel = 2'b00;
        cfg_bus.cfg_half = 16'd55;
        @(negedge clk);
        cfg_bus.cfg_we = 1'b0;
        check("rst_run_freq", {31'd0, sensor_freq}, 32'd0);
        check("rst_run_settled", {31'd0, settled}, 32'd0);
        rst_n = 1'b1;
        count_level(1'b0, 0, z);
        count_level(1'b1, 1, h);
        check("rst_base_first_low", z, 116);
        check("rst_base_high", h, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/color_sensor_emu.md
COLOR_SENSOR_EMU -- requirements
Module: color_sensor_emu

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 16, giving the number of clk cycles the output is held low after a filter or scale change.
REQ-002 The module SHALL have parameter DEF_HALF, default 100, giving the reset value of every channel's base half-period, in clk cycles.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port scale, input, 2 bits: the frequency-scaling select.
- 00 = power-down.
- 01 = 2%.
- 10 = 20%.
- 11 = 100%.
REQ-006 The module SHALL have port filter, input, 2 bits: the photodiode select.
- 00 = red.
- 01 = blue.
- 10 = clear.
- 11 = green.
REQ-007 The module SHALL have port oe_n, input, 1 bit: active-low output enable.
REQ-008 The module SHALL have port cfg_we, input, 1 bit: write strobe for a channel's base half-period.
REQ-009 The module SHALL have port cfg_sel, input, 2 bits: the channel written, using the same encoding as filter.
REQ-010 The module SHALL have port cfg_half, input, 16 bits: the base half-period value written.
REQ-011 The module SHALL have port sensor_freq, output, 1 bit: the emulated square-wave frequency output.
REQ-012 The module SHALL have port settled, output, 1 bit: high while in state RUN.

Function
REQ-013 The block SHALL hold four 16-bit base half-period registers, one per filter channel; cfg_we=1 SHALL load cfg_half into the channel selected by cfg_sel on that clk edge.
REQ-014 Effective half-period SHALL be 22-bit: base*1 for scale 11, base*5 for 10, base*50 for 01; a base of 0 SHALL be treated as 1.
REQ-015 The FSM SHALL have states OFF, SETTLE and RUN.
- OFF, whenever scale=00: sensor_freq=0, counters cleared.
- scale!=00 in OFF SHALL enter SETTLE.
REQ-016 SETTLE SHALL hold sensor_freq=0 for exactly SETTLE_CYCLES cycles, then enter RUN with the half-period counter at 0 and the internal wave level at 0.
REQ-017 In RUN, the half-period counter SHALL increment each cycle; on reaching effective_half-1, the internal wave level SHALL toggle and the counter SHALL return to 0.
- Resulting period = 2*effective_half cycles.
REQ-018 A change of filter or scale (to any non-00 value) in SETTLE or RUN SHALL restart SETTLE from count 0 on the next cycle; a change to scale=00 SHALL enter OFF.
REQ-019 The effective half-period SHALL be sampled at each counter reload (at RUN entry and at each toggle).
- A cfg write to the active channel SHALL take effect at the next toggle, never mid-half-period.
REQ-020 sensor_freq SHALL equal the internal wave level when oe_n=0, and 0 when oe_n=1.
- oe_n SHALL NOT stop or reset the counter; phase is preserved across oe_n toggles.
REQ-021 A cfg write and a filter change in the same cycle SHALL both take effect: the write lands, and SETTLE restarts.
REQ-022 The counter SHALL never wrap; the maximum effective_half (65535*50) SHALL fit in 22 bits.

Reset
REQ-023 With rst_n=0 at a clk edge, the block SHALL enter OFF with:
- sensor_freq=0;
- settled=0;
- counters 0;
- all four base registers = DEF_HALF.
REQ-024 Reset asserted mid-RUN SHALL take effect on that edge.
- No partial half-period is completed.
- cfg writes in the same cycle are ignored.

Configuration
REQ-025 With macro CSE_NOISE_EN defined, a 16-bit Galois LFSR (seed 16'hACE1 at reset, advanced once per toggle) SHALL jitter each reloaded effective half-period.
- LFSR bit0=1: +1. bit1=1 (bit0=0): -1 (floored at 1). Otherwise: unchanged.
REQ-026 Without CSE_NOISE_EN, no LFSR SHALL exist and the period SHALL be exact per REQ-017.

Structure
REQ-027 A shared package SHALL hold:
- the filter encodings (RED, BLUE, CLEAR, GREEN);
- the scale encodings (PD, S2, S20, S100);
- the scale multipliers (1, 5, 50);
- the FSM state enum.
REQ-028 One sub-module, cse_half_timer, SHALL contain the reload counter and toggle logic.
- The top SHALL contain the FSM, registers and output gating.

Verification
REQ-029 Reset, scale=11, filter=00, oe_n=0 -> sensor_freq low for 16 cycles after scale seen, first rise 100 cycles later, period 200.
REQ-030 scale=10 -> period 1000; scale=01 -> period 10000; scale=00 -> sensor_freq=0, settled=0 within 1 cycle.
REQ-031 Write cfg_sel=11, cfg_half=40 while filter=00 running, then filter=11 -> 16 low cycles, then period 80.
REQ-032 Write cfg_sel=00, cfg_half=30 mid-half-period on active red channel -> current half completes at 100, subsequent halves 30.
REQ-033 oe_n=1 for 150 cycles during RUN -> sensor_freq=0, then wave resumes at the same phase as an ungated reference model.
REQ-034 cfg_half=0, scale=11 -> period 2; rst_n=0 mid-RUN -> next cycle sensor_freq=0, base registers back to 100.
